// File: rtl/pc_pkg.sv
// Shared types and constants for the PC/redirect slice of the 5-stage MIPS datapath.
package pc_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FCNT_W      = 3;

  typedef enum logic {
    RUN,
    FLUSH
  } state_e;

  // Instruction fetches are word-aligned; the low two bits of a target are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Redirect inputs from the branch/jump logic and fetch-side outputs of the PC unit.
interface pc_redirect_unit_if
  import pc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic            BranchTaken;
  logic [PC_W-1:0] BranchTarget;
  logic            Jump;
  logic [PC_W-1:0] JumpTarget;
  logic            Stall;
  logic [PC_W-1:0] PC;
  logic [PC_W-1:0] PCPlus4;
  logic            Flush;
  logic            Redirect;
  logic            MisalignErr;
  logic [CNT_W-1:0] RedirCount;

  modport master (
    output BranchTaken, BranchTarget, Jump, JumpTarget, Stall,
    input  PC, PCPlus4, Flush, Redirect, MisalignErr, RedirCount
  );

  modport slave (
    input  BranchTaken, BranchTarget, Jump, JumpTarget, Stall,
    output PC, PCPlus4, Flush, Redirect, MisalignErr, RedirCount
  );

endinterface

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// PC register with branch/jump redirect, wrong-path flush FSM and redirect statistics.
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter int unsigned     CNT_W        = 16
) (
  input logic               Clk,
  input logic               Reset,
  pc_redirect_unit_if.slave bus
);

  localparam logic [FCNT_W-1:0] FlushInit = FCNT_W'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   target;
  logic              redir;
  logic              redirect_q;
  logic              misalign_q, misalign_d;

  // Branch beats jump when both fire; either one overrides a stall.
  assign redir    = bus.BranchTaken | bus.Jump;
  assign target   = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
  assign pc_plus4 = pc_q + PC_W'(INSTR_BYTES);

  always_comb begin
    pc_d       = pc_plus4;
    misalign_d = misalign_q;
    if (redir) begin
      pc_d       = align_pc(target);
      misalign_d = misalign_q | is_misaligned(target);
    end else if (bus.Stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (redir) begin
          state_d = FLUSH;
          fcnt_d  = FlushInit;
        end
      end
      FLUSH: begin
        // A new redirect restarts the squash window for the new wrong path.
        if (redir) begin
          fcnt_d = FlushInit;
        end else if (fcnt_q != '0) begin
          fcnt_d = fcnt_q - 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= RUN;
      fcnt_q     <= '0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      pc_q       <= pc_d;
      redirect_q <= redir;
      misalign_q <= misalign_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_redir_cnt (
    .clk_i   (Clk),
    .clr_i   (Reset),
    .inc_i   (redir),
    .count_o (bus.RedirCount)
  );

  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.Flush       = (state_q == FLUSH);
  assign bus.Redirect    = redirect_q;
  assign bus.MisalignErr = misalign_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  pc_redirect_unit_if #(.CNT_W(16)) bus_a ();
  pc_redirect_unit_if #(.CNT_W(2))  bus_b ();

  pc_redirect_unit #(
    .RESET_PC     (RESET_PC),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (16)
  ) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_a)
  );

  pc_redirect_unit #(
    .RESET_PC     (RESET_PC),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (2)
  ) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: remaining flush cycles and an unbounded redirect count.
  logic [31:0] m_pc    = '0;
  int          m_flush = 0;
  bit          m_redir = 0;
  bit          m_mis   = 0;
  int          m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/pc_a"},    bus_a.PC, m_pc);
    check({tag, "/pc_b"},    bus_b.PC, m_pc);
    check({tag, "/pc4_a"},   bus_a.PCPlus4, m_pc + 32'd4);
    check({tag, "/pc4_b"},   bus_b.PCPlus4, m_pc + 32'd4);
    check({tag, "/flush_a"}, 32'(bus_a.Flush), 32'(m_flush > 0));
    check({tag, "/flush_b"}, 32'(bus_b.Flush), 32'(m_flush > 0));
    check({tag, "/redir_a"}, 32'(bus_a.Redirect), 32'(m_redir));
    check({tag, "/redir_b"}, 32'(bus_b.Redirect), 32'(m_redir));
    check({tag, "/mis_a"},   32'(bus_a.MisalignErr), 32'(m_mis));
    check({tag, "/mis_b"},   32'(bus_b.MisalignErr), 32'(m_mis));
    check({tag, "/cnt_a"},   32'(bus_a.RedirCount), 32'(sat(m_cnt, 65535)));
    check({tag, "/cnt_b"},   32'(bus_b.RedirCount), 32'(sat(m_cnt, 3)));
  endtask

  task automatic step(input string tag, input logic rst, input logic bt,
                      input logic [31:0] btgt, input logic j, input logic [31:0] jtgt,
                      input logic st);
    logic [31:0] tgt;
    Reset              = rst;
    bus_a.BranchTaken  = bt;
    bus_a.BranchTarget = btgt;
    bus_a.Jump         = j;
    bus_a.JumpTarget   = jtgt;
    bus_a.Stall        = st;
    bus_b.BranchTaken  = bt;
    bus_b.BranchTarget = btgt;
    bus_b.Jump         = j;
    bus_b.JumpTarget   = jtgt;
    bus_b.Stall        = st;
    @(posedge Clk);
    if (rst) begin
      m_pc    = RESET_PC;
      m_flush = 0;
      m_redir = 0;
      m_mis   = 0;
      m_cnt   = 0;
    end else if (bt || j) begin
      tgt     = bt ? btgt : jtgt;
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_redir = 1;
      m_flush = FLUSH_CYCLES;
      if (tgt % 4 != 0) m_mis = 1;
      m_cnt++;
    end else begin
      m_redir = 0;
      if (!st) m_pc = m_pc + 32'd4;
      if (m_flush > 0) m_flush--;
    end
    #1;
    check_all(tag);
  endtask

  task automatic free(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic jump(input string tag, input logic [31:0] t);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b1, t, 1'b0);
  endtask

  task automatic branch(input string tag, input logic [31:0] t);
    step(tag, 1'b0, 1'b1, t, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] hold;
    int          guard;

    // Reset, then free-running fetch
    step("t1_rst", 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    step("t1_rst", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("t1_pc0", bus_a.PC, 32'h0);
    check("t1_cnt0", 32'(bus_a.RedirCount), 32'h0);
    free("t1_run");
    check("t1_pc4", bus_a.PC, 32'h4);
    free("t1_run");
    check("t1_pc8", bus_a.PC, 32'h8);
    free("t1_run");
    check("t1_pc12", bus_a.PC, 32'hC);

    // Taken branch from 0x40
    guard = 0;
    while (m_pc != 32'h40 && guard < 64) begin
      free("t2_walk");
      guard++;
    end
    check("t2_reach40", bus_a.PC, 32'h40);
    branch("t2_br", 32'h100);
    check("t2_pc", bus_a.PC, 32'h100);
    check("t2_redir", 32'(bus_a.Redirect), 32'h1);
    check("t2_flush1", 32'(bus_a.Flush), 32'h1);
    check("t2_cnt", 32'(bus_a.RedirCount), 32'h1);
    free("t2_f2");
    check("t2_redir_off", 32'(bus_a.Redirect), 32'h0);
    check("t2_flush2", 32'(bus_a.Flush), 32'h1);
    free("t2_f3");
    check("t2_flush_off", 32'(bus_a.Flush), 32'h0);

    // Jump overrides stall; stall alone holds PC
    step("t3_stall_jump", 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    check("t3_pc", bus_a.PC, 32'h200);
    free("t3_drain");
    free("t3_drain");
    hold = m_pc;
    for (int i = 0; i < 3; i++) begin
      step("t3_stall", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check("t3_hold", bus_a.PC, hold);
    end

    // Redirect during the first flush cycle extends the window
    jump("t4_jump", 32'h280);
    branch("t4_br", 32'h300);
    check("t4_pc", bus_a.PC, 32'h300);
    check("t4_flush2", 32'(bus_a.Flush), 32'h1);
    free("t4_f3");
    check("t4_flush3", 32'(bus_a.Flush), 32'h1);
    free("t4_f4");
    check("t4_flush_off", 32'(bus_a.Flush), 32'h0);

    // PC wrap and misaligned target
    jump("t5_jump", 32'hFFFF_FFFC);
    check("t5_pc4_wrap", bus_a.PCPlus4, 32'h0);
    free("t5_wrap");
    check("t5_pc_wrap", bus_a.PC, 32'h0);
    branch("t5_mis", 32'h102);
    check("t5_pc_aligned", bus_a.PC, 32'h100);
    check("t5_mis", 32'(bus_a.MisalignErr), 32'h1);
    for (int i = 0; i < 3; i++) free("t5_sticky");
    check("t5_sticky", 32'(bus_a.MisalignErr), 32'h1);

    // Reset mid-flush, then counter saturation
    jump("t6_jump", 32'h500);
    step("t6_rst", 1'b1, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0);
    check("t6_pc", bus_a.PC, RESET_PC);
    check("t6_flush", 32'(bus_a.Flush), 32'h0);
    check("t6_mis", 32'(bus_a.MisalignErr), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step("t6_redir", 1'b0, 1'b1, 32'h1000 + 32'(i * 16), 1'b1, 32'h2000, 1'b0);
    end
    check("t6_sat_b", 32'(bus_b.RedirCount), 32'h3);
    check("t6_cnt_a", 32'(bus_a.RedirCount), 32'h5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, $urandom,
           $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
